gf_pow_seq: RTL

- Sequential GF(2^m) exponentiation controller: computes result = base^exponent mod P(x) by right-to-left square-and-multiply.
- Sits upstream of and around the combinational carry-less multiply/reduce datapath. It reuses one multiply-reduce instance per cycle, iterated by an FSM.
- Main use is field inversion (a^(2^m-2)) and general powers for the GF operations suite.
- Field polynomial and degree are runtime inputs, latched at start.

---
 rtl/gf_pkg.sv | 27 ++
 rtl/gf_mulred.sv | 35 +++
 rtl/gf_pow_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) power controller: FSM states, the field
// unit element and the legal reduction-polynomial check.
package gf_pkg;

    localparam int unsigned POLY_MAX_W = 65;
    localparam int unsigned GF_ONE     = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        SQR  = 3'd3,
        DONE = 3'd4
    } state_t;

    // P(x) is usable when 2 <= degree <= dw and its leading coefficient is set
    function automatic logic poly_legal(input logic [POLY_MAX_W-1:0] poly,
                                        input int unsigned           grade,
                                        input int unsigned           dw);
        logic ok;
        ok = 1'b0;
        if ((grade >= 32'd2) && (grade <= dw) && (grade < POLY_MAX_W))
            ok = poly[grade];
        return ok;
    endfunction

endpackage

// File: rtl/gf_mulred.sv
// Combinational carry-less multiply followed by reduction modulo P(x) of a
// runtime-selected degree; coefficients at or above that degree are cleared.
module gf_mulred #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         a,
    input  logic [DATA_WIDTH-1:0]         b,
    input  logic [DATA_WIDTH:0]           polyn_red_in,
    input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
    output logic [DATA_WIDTH-1:0]         out
);

    localparam int unsigned PW = 2 * DATA_WIDTH - 1;

    logic [PW-1:0] w_prod;
    logic [PW-1:0] w_red;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (b[i]) w_prod = w_prod ^ (PW'(a) << i);
        end
        // Clear each coefficient from the top down by folding in a shifted P(x)
        w_red = w_prod;
        for (int i = int'(PW) - 1; i >= 0; i--) begin
            if ((i >= int'(polyn_grade)) && w_red[i])
                w_red = w_red ^ (PW'(polyn_red_in) << (i - int'(polyn_grade)));
        end
        out = '0;
        for (int j = 0; j < int'(DATA_WIDTH); j++) begin
            out[j] = w_red[j] & (j < int'(polyn_grade));
        end
    end

endmodule

// File: rtl/gf_pow_seq.sv
// Sequential GF(2^m) exponentiation (right-to-left square-and-multiply) that
// time-shares a single multiply-reduce unit across LOAD/MUL/SQR cycles.
module gf_pow_seq
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         base,
    input  logic [DATA_WIDTH-1:0]         exponent,
    input  logic [DATA_WIDTH:0]           polyn_red_in,
    input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         result
);

    localparam int unsigned GW = $clog2(DATA_WIDTH) + 1;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0] r_exp;
    logic [DATA_WIDTH:0]   r_poly;
    logic [GW-1:0]         r_grade;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_sq;
    logic                  r_cfg_err;

    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_mr;
    logic                  w_legal;
    logic                  w_accept;

    // Operand steering for the shared multiplier
    always_comb begin
        w_a = r_sq;
        w_b = r_sq;
        case (r_state)
            LOAD: begin
                w_a = r_base;
                w_b = DATA_WIDTH'(GF_ONE);
            end
            MUL: begin
                w_a = r_acc;
                w_b = r_sq;
            end
            default: ;
        endcase
    end

    assign w_legal  = poly_legal(POLY_MAX_W'(polyn_red_in), 32'(polyn_grade), DATA_WIDTH);
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    gf_mulred #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mulred (
        .a            (w_a),
        .b            (w_b),
        .polyn_red_in (r_poly),
        .polyn_grade  (r_grade),
        .out          (w_mr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_exp     <= '0;
            r_poly    <= '0;
            r_grade   <= '0;
            r_acc     <= '0;
            r_sq      <= '0;
            r_cfg_err <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: ;
                LOAD: begin
                    r_sq  <= w_mr;
                    r_acc <= DATA_WIDTH'(GF_ONE);
                    if (r_exp == '0)   r_state <= DONE;
                    else if (r_exp[0]) r_state <= MUL;
                    else               r_state <= SQR;
                end
                MUL: begin
                    r_acc   <= w_mr;
                    r_state <= (r_exp[DATA_WIDTH-1:1] != '0) ? SQR : DONE;
                end
                // Entered only when a higher exponent bit is still set
                SQR: begin
                    r_sq    <= w_mr;
                    r_exp   <= r_exp >> 1;
                    r_state <= r_exp[1] ? MUL : SQR;
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    err     <= r_cfg_err;
                    result  <= r_cfg_err ? '0 : r_acc;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept) begin
                r_base    <= base;
                r_exp     <= exponent;
                r_poly    <= polyn_red_in;
                r_grade   <= polyn_grade;
                r_cfg_err <= !w_legal;
                busy      <= 1'b1;
                r_state   <= w_legal ? LOAD : DONE;
            end
        end
    end

endmodule
